// File: rtl/clk_en_nco_pkg.sv
// clk_en_nco_pkg
// Shared definitions for the clk_en_nco block:
//   - lock_state_t   : lock-FSM state encoding (RESET, SETTLE, LOCKED)
//   - DEF_ACC_W      : default phase-accumulator / increment width
//   - DEF_LOCK_CYCLES: default settle count before locked asserts
//   - LOCK_CNT_W     : width of the settle counter (covers up to 1023)
package clk_en_nco_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_t;

  localparam int unsigned DEF_ACC_W       = 24;
  localparam int unsigned DEF_LOCK_CYCLES = 16;
  localparam int unsigned LOCK_CNT_W      = 10;

endpackage

// File: rtl/clk_en_nco_ch.sv
// clk_en_nco_ch
// One numerically-controlled clock-enable channel. Every edge the channel
// adds its increment to a phase accumulator; the carry out of that addition
// is registered as a one-cycle enable pulse. A new increment is staged as
// "pending" and swapped in only on a carry edge (or immediately on the next
// edge when the channel is stopped), so no period is ever cut short.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   cfg_we   in   accepted increment write for this channel (only when !pending)
//   cfg_inc  in   [ACC_W] increment carried by the write
//   sync     in   phase-align strobe: clear acc, apply pending, suppress pulse
//   en       out  registered carry (clock-enable pulse)
//   pending  out  an accepted increment is waiting for its switch edge
module clk_en_nco_ch
  import clk_en_nco_pkg::*;
#(
  parameter int unsigned      ACC_W    = DEF_ACC_W,
  parameter logic [ACC_W-1:0] INIT_INC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic             sync,
  output logic             en,
  output logic             pending
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] pend_inc;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             apply;

  // inc == 0 gives sum == acc with no carry, so a stopped channel holds
  // its phase and never pulses without any special casing.
  assign sum   = {1'b0, acc} + {1'b0, inc};
  assign carry = sum[ACC_W];

  // Switch on the carry edge: this edge's update still uses the old
  // increment, the new one drives the update after it. A stopped channel
  // has no carry to wait for, so it switches on the first edge available.
  assign apply = pending && (carry || (inc == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      inc      <= INIT_INC;
      pend_inc <= '0;
      pending  <= 1'b0;
      en       <= 1'b0;
    end else begin
      if (sync) begin
        acc     <= '0;
        en      <= 1'b0;
        pending <= 1'b0;
        if (pending) begin
          inc <= pend_inc;
        end
      end else begin
        acc <= sum[ACC_W-1:0];
        en  <= carry;
        if (apply) begin
          inc     <= pend_inc;
          pending <= 1'b0;
        end
      end
      // A write is only accepted while nothing is pending, so it never
      // collides with an apply. A write landing on a carry edge sees the
      // old (clear) pending flag and therefore waits for the next carry.
      if (cfg_we) begin
        pend_inc <= cfg_inc;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_en_nco.sv
// clk_en_nco
// Multi-channel NCO clock-enable generator with a lock indicator.
// Each channel produces en_out[ch] pulses at mean rate f_clk*inc/2^ACC_W.
// Increments are updated through a valid/ready port and switched in
// glitch-free on the channel's carry edge. locked asserts once every
// channel has been running at its configured rate for LOCK_CYCLES edges.
//
// Optional feature: define CLK_EN_NCO_SYNC_EN to add sync_in, which clears
// every accumulator, applies all pending increments and restarts settling.
//
// Parameters: NUM_CH (1..8), ACC_W (8..32), INIT_INC, LOCK_CYCLES (1..1023)
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   sync_in     in   phase-align strobe (CLK_EN_NCO_SYNC_EN only)
//   cfg_valid   in   increment update request
//   cfg_ch      in   [3] target channel
//   cfg_inc     in   [ACC_W] new increment
//   cfg_ready   out  update can be accepted this cycle
//   en_out      out  [NUM_CH] one-cycle clock-enable pulses
//   locked      out  all channels settled
//   lock_state  out  lock-FSM state (debug)
//
// Handshake: a transfer happens on a rising edge where cfg_valid and
// cfg_ready are both high. cfg_ready depends only on cfg_ch and the
// pending flags (never on cfg_valid); it is low while the addressed channel
// still holds an unapplied increment. Writes to cfg_ch >= NUM_CH are always
// ready, are accepted, and are dropped without touching any state.
module clk_en_nco
  import clk_en_nco_pkg::*;
#(
  parameter int unsigned      NUM_CH      = 2,
  parameter int unsigned      ACC_W       = DEF_ACC_W,
  parameter logic [ACC_W-1:0] INIT_INC    = '0,
  parameter int unsigned      LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CLK_EN_NCO_SYNC_EN
  input  logic              sync_in,
`endif
  input  logic              cfg_valid,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] en_out,
  output logic              locked,
  output lock_state_t       lock_state
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_CYCLES - 1);

  logic [NUM_CH-1:0]     pending;
  logic [7:0]            pend_pad;
  logic                  in_range;
  logic                  cfg_fire;
  logic                  cfg_hit;
  logic                  any_pending;
  logic                  sync_pulse;

  lock_state_t           state;
  lock_state_t           state_nxt;
  logic [LOCK_CNT_W-1:0] cnt;
  logic [LOCK_CNT_W-1:0] cnt_nxt;

`ifdef CLK_EN_NCO_SYNC_EN
  assign sync_pulse = sync_in;
`else
  assign sync_pulse = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Config port
  // ---------------------------------------------------------------------
  // Pad to the full 3-bit index range so cfg_ch can index it directly.
  assign pend_pad  = 8'(pending);
  assign in_range  = ({1'b0, cfg_ch} < 4'(NUM_CH));
  // Reset forces ready high, independent of the stale pending flags.
  assign cfg_ready = rst || !in_range || !pend_pad[cfg_ch];
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign cfg_hit   = cfg_fire && in_range && !rst;

  assign any_pending = |pending;

  // ---------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    clk_en_nco_ch #(
      .ACC_W   (ACC_W),
      .INIT_INC(INIT_INC)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .cfg_we (cfg_hit && (cfg_ch == 3'(i))),
      .cfg_inc(cfg_inc),
      .sync   (sync_pulse),
      .en     (en_out[i]),
      .pending(pending[i])
    );
  end

  // ---------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RESET;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RESET: begin
        state_nxt = ST_SETTLE;
        cnt_nxt   = '0;
      end
      ST_SETTLE: begin
        // A fresh write or a sync restarts settling just like a pending
        // flag does: the channel rates are about to change.
        if (sync_pulse || cfg_hit || any_pending) begin
          cnt_nxt = '0;
        end else if (cnt == LOCK_LAST) begin
          state_nxt = ST_LOCKED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (sync_pulse || cfg_hit) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_RESET;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign locked     = (state == ST_LOCKED);
  assign lock_state = state;

endmodule

// File: doc/clk_en_nco.md
CLK_EN_NCO -- requirements
Module: clk_en_nco

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent clock-enable channels, 1..8.
REQ-002 Parameter ACC_W, default 24: phase-accumulator and increment width, 8..32.
REQ-003 Parameter INIT_INC, default 0: increment loaded into every channel at reset (0 = channel stopped).
REQ-004 Parameter LOCK_CYCLES, default 16: settle count before locked asserts, 1..1023.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 cfg_valid  in  1  increment-update request.
REQ-008 cfg_ch  in  3  target channel index.
REQ-009 cfg_inc  in  ACC_W  new increment.
REQ-010 cfg_ready  out  1  update can be accepted this cycle.
REQ-011 sync_in  in  1  phase-align strobe; present only with CLK_EN_NCO_SYNC_EN.
REQ-012 en_out  out  NUM_CH  one-cycle clock-enable pulse per channel.
REQ-013 locked  out  1  all channels settled at their configured rate.

Function
REQ-014 Each enabled edge, each channel SHALL compute an (ACC_W+1)-bit sum acc+inc, store the low ACC_W bits in acc, and register the carry bit into en_out[ch].
REQ-015 en_out[ch] SHALL be high for exactly one cycle, on the edge after the carry-producing update; mean pulse rate = f_clk*inc/2^ACC_W.
REQ-016 inc=0 SHALL hold acc and keep en_out[ch] low.
REQ-017 Transfer SHALL occur when cfg_valid and cfg_ready are both high on an edge; cfg_ready = NOT pending[cfg_ch] for cfg_ch < NUM_CH.
REQ-018 An accepted increment SHALL become pending and SHALL replace inc on that channel's next carry edge, taking effect from the following update (no partial period).
REQ-019 If the channel's current inc is 0, the pending value SHALL be applied on the edge after acceptance.
REQ-020 Acceptance on the same edge as a carry of that channel SHALL defer application to the next carry.
REQ-021 cfg_ch >= NUM_CH: cfg_ready high, transfer accepted and discarded, no state or locked change.
REQ-022 Lock FSM states: RESET, SETTLE, LOCKED. RESET->SETTLE on first edge with rst low; SETTLE counts edges with no pending bit set, counter held at 0 while any pending; SETTLE->LOCKED when count reaches LOCK_CYCLES; LOCKED->SETTLE (counter 0) on any accepted in-range transfer.
REQ-023 locked SHALL be high only in LOCKED.

Reset
REQ-024 While rst is high: acc=0, inc=INIT_INC, pending=0, en_out=0, locked=0, FSM=RESET, cfg_ready=1.
REQ-025 rst asserted mid-operation SHALL discard pending updates and restart lock counting from RESET.

Configuration
REQ-026 With CLK_EN_NCO_SYNC_EN defined, sync_in high on an edge SHALL clear every acc to 0, apply every pending increment, force en_out to 0 on that edge, and move LOCKED/SETTLE to SETTLE with counter 0.
REQ-027 Without CLK_EN_NCO_SYNC_EN, sync_in SHALL not exist and accumulators run free-phased.

Structure
REQ-028 Package clk_en_nco_pkg SHALL hold the lock-FSM state enum and default ACC_W/LOCK_CYCLES constants.
REQ-029 One sub-module clk_en_nco_ch SHALL implement one channel (acc, inc, pending, carry register), instantiated NUM_CH times.

Verification
REQ-030 ACC_W=24, INIT_INC=2^22, release rst -> en_out[0] first pulses after the 4th edge, then every 4 cycles.
REQ-031 Running inc=2^22, write 2^21 mid-period -> current 4-cycle period completes, then pulses every 8 cycles; cfg_ready low until the switch.
REQ-032 LOCK_CYCLES=16, no config -> locked rises exactly 16 edges after RESET->SETTLE; accepted write drops it next edge and re-locks 16 edges after pending clears.
REQ-033 cfg_ch=5, NUM_CH=2 -> accepted, en_out cadence and locked unchanged.
REQ-034 With CLK_EN_NCO_SYNC_EN, channels at 2^22 and 2^23 skewed, pulse sync_in -> both channels pulse together 2 edges later (ch1) and 4 edges later (ch0, coincident with ch1's 2nd pulse).
REQ-035 Assert rst for 1 cycle during a pending update -> pending lost, inc=INIT_INC, locked low.
